// File: rtl/usb_tx_sched_pkg.sv
// Shared definitions for the USB device transmit scheduler: handshake and
// data PID selectors, FSM states and endpoint-index width helper.
package usb_tx_sched_pkg;

    localparam logic [1:0] HskAck   = 2'b00;
    localparam logic [1:0] HskNak   = 2'b10;
    localparam logic [1:0] HskStall = 2'b11;

    localparam logic [1:0] TrnData0 = 2'b00;
    localparam logic [1:0] TrnData1 = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StHsk,
        StHskEnd,
        StDpid,
        StDxfer,
        StDack
    } state_e;

    // Width of an endpoint index, never below one bit.
    function automatic int unsigned epw(int unsigned n);
        if (n > 1) begin
            return unsigned'($clog2(n));
        end
        return 32'd1;
    endfunction

    function automatic logic [1:0] data_type(logic tog);
        return tog ? TrnData1 : TrnData0;
    endfunction

endpackage

// File: rtl/usb_tx_sched_if.sv
// Scheduler <-> usb_encode connection: handshake port, transaction stream and
// taps of the encoder's transmit output.
interface usb_tx_sched_if;

    logic       hsk_send;
    logic [1:0] hsk_type;
    logic       hsk_done;
    logic       trn_start;
    logic [1:0] trn_type;
    logic       trn_tvalid;
    logic       trn_tready;
    logic       trn_tlast;
    logic [7:0] trn_tdata;
    logic       mon_tvalid;
    logic       mon_tready;
    logic       mon_tlast;

    modport master (
        output hsk_send, hsk_type, trn_start, trn_type, trn_tvalid, trn_tlast, trn_tdata,
        input  hsk_done, trn_tready, mon_tvalid, mon_tready, mon_tlast
    );

    modport slave (
        input  hsk_send, hsk_type, trn_start, trn_type, trn_tvalid, trn_tlast, trn_tdata,
        output hsk_done, trn_tready, mon_tvalid, mon_tready, mon_tlast
    );

endinterface

// File: rtl/usb_tx_sched_ep_mux.sv
// NUM_EP-way AXI-S byte mux: routes the selected endpoint source to one sink
// while enabled; every other source sees tready low.
module usb_tx_sched_ep_mux
    import usb_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_EP = 4
) (
    input  logic                      en_i,
    input  logic [epw(NUM_EP)-1:0]    sel_i,
    input  logic [NUM_EP-1:0]         s_tvalid_i,
    output logic [NUM_EP-1:0]         s_tready_o,
    input  logic [NUM_EP-1:0]         s_tlast_i,
    input  logic [8*NUM_EP-1:0]       s_tdata_i,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic                      m_tlast_o,
    output logic [7:0]                m_tdata_o
);

    localparam int unsigned EPW = epw(NUM_EP);

    always_comb begin
        s_tready_o = '0;
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        m_tdata_o  = 8'h00;
        for (int k = 0; k < NUM_EP; k++) begin
            if (en_i && sel_i == EPW'(k)) begin
                s_tready_o[k] = m_tready_i;
                m_tvalid_o    = s_tvalid_i[k];
                m_tlast_o     = s_tlast_i[k];
                m_tdata_o     = s_tdata_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/usb_tx_sched.sv
// Device-side transmit scheduler in front of usb_encode: sends handshakes and
// IN data packets, tracks DATA0/1 toggles and waits for the host ACK.
module usb_tx_sched
    import usb_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_EP  = 4,
    parameter int unsigned TIMEOUT = 816
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   hsk_req_i,
    input  logic [1:0]             hsk_sel_i,
    output logic                   hsk_ack_o,
    input  logic                   dat_req_i,
    input  logic [epw(NUM_EP)-1:0] dat_ep_i,
    input  logic                   dat_zlp_i,
    output logic                   dat_ack_o,
    output logic                   dat_ok_o,
    input  logic                   ack_rcvd_i,
    input  logic                   setup_i,
    input  logic [epw(NUM_EP)-1:0] setup_ep_i,
    input  logic [NUM_EP-1:0]      ep_tvalid_i,
    output logic [NUM_EP-1:0]      ep_tready_o,
    input  logic [NUM_EP-1:0]      ep_tlast_i,
    input  logic [8*NUM_EP-1:0]    ep_tdata_i,
    usb_tx_sched_if.master         enc,
    output logic                   busy_o
);

    localparam int unsigned EPW = epw(NUM_EP);
    localparam int unsigned CW  = $clog2(TIMEOUT);

    state_e            state_q, state_d;
    logic [NUM_EP-1:0] tog_q, tog_d;
    logic [EPW-1:0]    ep_q, ep_d;
    logic              zlp_q, zlp_d;
    logic [1:0]        hsk_type_q, hsk_type_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              hsk_ack_q, hsk_ack_d;
    logic              dat_ack_q, dat_ack_d;
    logic              dat_ok_q, dat_ok_d;

    logic       mux_en;
    logic       mux_tvalid;
    logic       mux_tlast;
    logic [7:0] mux_tdata;
    logic       tx_last_fire;

    assign tx_last_fire = enc.mon_tvalid & enc.mon_tready & enc.mon_tlast;

    always_comb begin
        state_d    = state_q;
        tog_d      = tog_q;
        ep_d       = ep_q;
        zlp_d      = zlp_q;
        hsk_type_d = hsk_type_q;
        cnt_d      = cnt_q;
        hsk_ack_d  = 1'b0;
        dat_ack_d  = 1'b0;
        dat_ok_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hsk_req_i) begin
                    state_d    = StHsk;
                    hsk_type_d = hsk_sel_i;
                end else if (dat_req_i) begin
                    state_d = StDpid;
                    // Out-of-range endpoints degrade to a ZLP on endpoint 0.
                    if (32'(dat_ep_i) < NUM_EP) begin
                        ep_d  = dat_ep_i;
                        zlp_d = dat_zlp_i;
                    end else begin
                        ep_d  = '0;
                        zlp_d = 1'b1;
                    end
                end
            end
            StHsk: begin
                if (enc.hsk_done) begin
                    state_d   = StHskEnd;
                    hsk_ack_d = 1'b1;
                end
            end
            StHskEnd: begin
                if (!enc.hsk_done) begin
                    state_d = StIdle;
                end
            end
            StDpid: begin
                state_d = StDxfer;
            end
            StDxfer: begin
                if (tx_last_fire) begin
                    state_d = StDack;
                    cnt_d   = '0;
                end
            end
            StDack: begin
                cnt_d = cnt_q + CW'(1);
                if (ack_rcvd_i) begin
                    tog_d[ep_q] = ~tog_q[ep_q];
                    dat_ack_d   = 1'b1;
                    dat_ok_d    = 1'b1;
                    state_d     = StIdle;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    dat_ack_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Applied last so SETUP overrides an ACK flip on the same endpoint.
        if (setup_i && 32'(setup_ep_i) < NUM_EP) begin
            tog_d[setup_ep_i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            tog_q      <= '0;
            ep_q       <= '0;
            zlp_q      <= 1'b0;
            hsk_type_q <= 2'b00;
            cnt_q      <= '0;
            hsk_ack_q  <= 1'b0;
            dat_ack_q  <= 1'b0;
            dat_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tog_q      <= tog_d;
            ep_q       <= ep_d;
            zlp_q      <= zlp_d;
            hsk_type_q <= hsk_type_d;
            cnt_q      <= cnt_d;
            hsk_ack_q  <= hsk_ack_d;
            dat_ack_q  <= dat_ack_d;
            dat_ok_q   <= dat_ok_d;
        end
    end

    assign mux_en = (state_q == StDxfer) && !zlp_q;

    usb_tx_sched_ep_mux #(
        .NUM_EP (NUM_EP)
    ) u_ep_mux (
        .en_i       (mux_en),
        .sel_i      (ep_q),
        .s_tvalid_i (ep_tvalid_i),
        .s_tready_o (ep_tready_o),
        .s_tlast_i  (ep_tlast_i),
        .s_tdata_i  (ep_tdata_i),
        .m_tvalid_o (mux_tvalid),
        .m_tready_i (enc.trn_tready),
        .m_tlast_o  (mux_tlast),
        .m_tdata_o  (mux_tdata)
    );

    always_comb begin
        enc.hsk_send   = (state_q == StHsk);
        enc.hsk_type   = hsk_type_q;
        enc.trn_start  = (state_q == StDpid);
        enc.trn_type   = (state_q == StDpid) ? data_type(tog_q[ep_q]) : 2'b00;
        enc.trn_tvalid = mux_tvalid;
        // A ZLP is signalled as tlast without tvalid alongside the start strobe.
        enc.trn_tlast  = (state_q == StDpid) ? zlp_q : mux_tlast;
        enc.trn_tdata  = mux_tdata;
    end

    assign hsk_ack_o = hsk_ack_q;
    assign dat_ack_o = dat_ack_q;
    assign dat_ok_o  = dat_ok_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_usb_tx_sched.sv
// Bench for usb_tx_sched: behavioural encoder and endpoint sources, a byte
// scoreboard on the encoder output and a table of handshake/data transactions.
module tb_usb_tx_sched;
    import usb_tx_sched_pkg::*;

    localparam int unsigned NUM_EP  = 4;
    localparam int unsigned TIMEOUT = 816;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                hsk_req = 1'b0;
    logic [1:0]          hsk_sel = 2'b00;
    logic                hsk_ack;
    logic                dat_req = 1'b0;
    logic [1:0]          dat_ep = 2'b00;
    logic                dat_zlp = 1'b0;
    logic                dat_ack;
    logic                dat_ok;
    logic                ack_rcvd = 1'b0;
    logic                setup = 1'b0;
    logic [1:0]          setup_ep = 2'b00;
    logic [NUM_EP-1:0]   ep_tvalid = '0;
    logic [NUM_EP-1:0]   ep_tready;
    logic [NUM_EP-1:0]   ep_tlast = '0;
    logic [8*NUM_EP-1:0] ep_tdata = '0;
    logic                busy;

    usb_tx_sched_if enc ();

    always #5 clock = ~clock;

    usb_tx_sched #(
        .NUM_EP  (NUM_EP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .hsk_req_i   (hsk_req),
        .hsk_sel_i   (hsk_sel),
        .hsk_ack_o   (hsk_ack),
        .dat_req_i   (dat_req),
        .dat_ep_i    (dat_ep),
        .dat_zlp_i   (dat_zlp),
        .dat_ack_o   (dat_ack),
        .dat_ok_o    (dat_ok),
        .ack_rcvd_i  (ack_rcvd),
        .setup_i     (setup),
        .setup_ep_i  (setup_ep),
        .ep_tvalid_i (ep_tvalid),
        .ep_tready_o (ep_tready),
        .ep_tlast_i  (ep_tlast),
        .ep_tdata_i  (ep_tdata),
        .enc         (enc),
        .busy_o      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] hsk_pid(input logic [1:0] sel);
        case (sel)
            2'b00:   return 8'hD2;
            2'b10:   return 8'h5A;
            2'b11:   return 8'h1E;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- encoder model and endpoint sources ----------------
    logic [7:0]  txq[$];
    bit          txl[$];
    logic [7:0]  sbq[$];
    logic [7:0]  epq[NUM_EP][$];
    logic [15:0] enc_crc;
    bit          hsk_busy = 1'b0;
    int          pkt_done_cnt = 0;
    int          hsk_ack_cnt = 0;
    int          dat_ack_cnt = 0;
    logic [NUM_EP-1:0] rdy_seen = '0;

    bit                s_rst, s_hsk_send, s_start, s_tlast, s_beat, s_mon;
    logic [1:0]        s_hsk_type, s_type;
    logic [7:0]        s_tdata, e_byte;
    bit                e_last;
    logic [NUM_EP-1:0] s_rdy, s_epfire;

    task automatic push_crc();
        logic [15:0] c;
        c = ~enc_crc;
        txq.push_back(c[7:0]);  txl.push_back(1'b0);
        txq.push_back(c[15:8]); txl.push_back(1'b1);
    endtask

    always @(negedge clock) begin
        if (hsk_ack) hsk_ack_cnt++;
        if (dat_ack) dat_ack_cnt++;
    end

    initial begin
        enc.hsk_done   = 1'b0;
        enc.trn_tready = 1'b0;
        enc.mon_tvalid = 1'b0;
        enc.mon_tready = 1'b0;
        enc.mon_tlast  = 1'b0;
        forever begin
            @(negedge clock);
            s_rst      = !reset_n;
            s_hsk_send = enc.hsk_send;
            s_hsk_type = enc.hsk_type;
            s_start    = enc.trn_start;
            s_type     = enc.trn_type;
            s_tlast    = enc.trn_tlast;
            s_beat     = enc.trn_tvalid && enc.trn_tready;
            s_tdata    = enc.trn_tdata;
            s_mon      = enc.mon_tvalid && enc.mon_tready;
            s_rdy      = ep_tready;
            s_epfire   = ep_tready & ep_tvalid;
            @(posedge clock);
            #1;
            if (s_rst) begin
                txq.delete();
                txl.delete();
                for (int k = 0; k < NUM_EP; k++) epq[k].delete();
                hsk_busy     = 1'b0;
                enc.hsk_done = 1'b0;
            end else begin
                rdy_seen |= s_rdy;
                if (enc.hsk_done && !s_hsk_send) enc.hsk_done = 1'b0;
                if (s_mon) begin
                    e_byte = txq.pop_front();
                    e_last = txl.pop_front();
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_byte: got 0x%0h, expected no byte", e_byte);
                    end else begin
                        check("tx_byte", 32'(e_byte), 32'(sbq.pop_front()));
                    end
                    if (e_last && hsk_busy) begin
                        hsk_busy     = 1'b0;
                        enc.hsk_done = 1'b1;
                    end else if (e_last) begin
                        pkt_done_cnt++;
                    end
                end
                if (s_hsk_send && !hsk_busy && !enc.hsk_done) begin
                    txq.push_back(hsk_pid(s_hsk_type));
                    txl.push_back(1'b1);
                    hsk_busy = 1'b1;
                end
                if (s_start) begin
                    txq.push_back(s_type == 2'b10 ? 8'h4B : 8'hC3);
                    txl.push_back(1'b0);
                    enc_crc = 16'hFFFF;
                    if (s_tlast && !s_beat) push_crc();
                end
                if (s_beat && !s_start) begin
                    txq.push_back(s_tdata);
                    txl.push_back(1'b0);
                    enc_crc = crc16_upd(enc_crc, s_tdata);
                    if (s_tlast) push_crc();
                end
                for (int k = 0; k < NUM_EP; k++) begin
                    if (s_epfire[k]) void'(epq[k].pop_front());
                end
            end
            enc.trn_tready = ($urandom_range(0, 3) != 0);
            enc.mon_tready = ($urandom_range(0, 3) != 0);
            enc.mon_tvalid = (txq.size() > 0);
            enc.mon_tlast  = (txq.size() > 0) ? txl[0] : 1'b0;
            for (int k = 0; k < NUM_EP; k++) begin
                ep_tvalid[k]        = (epq[k].size() > 0);
                ep_tlast[k]         = (epq[k].size() == 1);
                ep_tdata[8*k +: 8]  = (epq[k].size() > 0) ? epq[k][0] : 8'h00;
            end
        end
    end

    // ---------------- transaction table ----------------
    typedef struct {
        bit         hsk;
        logic [1:0] sel;
        int         ep;
        bit         zlp;
        int         len;
        logic [7:0] first;
        int         ack_dly;   // -1: host never ACKs
        int         setup_ep;  // -1: no SETUP before the request
        bit         setup_with_ack;
        logic [7:0] pid;
        bit         ok;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t hv(input logic [1:0] sel, input logic [7:0] pid);
        vec_t v;
        v = '{1'b1, sel, 0, 1'b0, 0, 8'h00, 0, -1, 1'b0, pid, 1'b1};
        return v;
    endfunction

    function automatic vec_t dv(input int ep, input bit zlp, input int len, input logic [7:0] first,
                                input int ack_dly, input int sep, input bit swa,
                                input logic [7:0] pid, input bit ok);
        vec_t v;
        v = '{1'b0, 2'b00, ep, zlp, len, first, ack_dly, sep, swa, pid, ok};
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_before_request", 32'(busy), 32'd0);
    endtask

    task automatic queue_packet(input vec_t v);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        sbq.push_back(v.pid);
        if (!v.zlp) begin
            for (int i = 0; i < v.len; i++) begin
                b = v.first + 8'(i);
                epq[v.ep].push_back(b);
                sbq.push_back(b);
                c = crc16_upd(c, b);
            end
        end
        c = ~c;
        sbq.push_back(c[7:0]);
        sbq.push_back(c[15:8]);
    endtask

    task automatic run_hsk(input vec_t v);
        int n, c0;
        c0 = hsk_ack_cnt;
        sbq.push_back(v.pid);
        hsk_sel = v.sel;
        hsk_req = 1'b1;
        tick();
        check("hsk_send_latency", 32'(enc.hsk_send), 32'd1);
        n = 0;
        while (!hsk_ack && n < 200) begin
            tick();
            n++;
        end
        check("hsk_ack", 32'(hsk_ack), 32'd1);
        hsk_req = 1'b0;
        repeat (3) tick();
        check("hsk_ack_pulses", 32'(hsk_ack_cnt - c0), 32'd1);
        check("hsk_busy_after", 32'(busy), 32'd0);
    endtask

    // Waits for the CRC byte to leave the encoder, then applies host response.
    task automatic finish_data(input vec_t v, input int d0);
        int n;
        n = 0;
        while (pkt_done_cnt == d0 && n < 2000) begin
            tick();
            n++;
        end
        check("pkt_sent", 32'(pkt_done_cnt - d0), 32'd1);
        if (v.ack_dly >= 0) begin
            repeat (v.ack_dly) tick();
            ack_rcvd = 1'b1;
            if (v.setup_with_ack) begin
                setup_ep = 2'(v.ep);
                setup    = 1'b1;
            end
            tick();
            ack_rcvd = 1'b0;
            setup    = 1'b0;
            check("dat_ack_latency", 32'(dat_ack), 32'd1);
            check("dat_ok", 32'(dat_ok), 32'(v.ok));
        end else begin
            n = 0;
            while (!dat_ack && n < int'(TIMEOUT) + 20) begin
                tick();
                n++;
            end
            check("timeout_cycles", 32'(n), 32'(TIMEOUT));
            check("dat_ok_timeout", 32'(dat_ok), 32'd0);
        end
        dat_req = 1'b0;
    endtask

    task automatic run_dat(input vec_t v);
        int c0, d0;
        c0 = dat_ack_cnt;
        d0 = pkt_done_cnt;
        if (v.setup_ep >= 0) begin
            setup_ep = 2'(v.setup_ep);
            setup    = 1'b1;
            tick();
            setup = 1'b0;
        end
        queue_packet(v);
        rdy_seen = '0;
        dat_ep   = 2'(v.ep);
        dat_zlp  = v.zlp;
        dat_req  = 1'b1;
        tick();
        check("trn_start_latency", 32'(enc.trn_start), 32'd1);
        finish_data(v, d0);
        tick();
        check("dat_ack_pulses", 32'(dat_ack_cnt - c0), 32'd1);
        check("ep_tready_mask", 32'(rdy_seen), v.zlp ? 32'd0 : (32'd1 << v.ep));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n, c0, d0, h0;

        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hsk_send", 32'(enc.hsk_send), 32'd0);
        check("rst_trn_start", 32'(enc.trn_start), 32'd0);
        check("rst_ep_tready", 32'(ep_tready), 32'd0);
        check("rst_dat_ack", 32'(dat_ack), 32'd0);
        reset_n = 1'b1;
        tick();

        vecs.push_back(hv(2'b10, 8'h5A));
        vecs.push_back(hv(2'b00, 8'hD2));
        vecs.push_back(hv(2'b11, 8'h1E));
        vecs.push_back(dv(1, 0, 3, 8'h01, 20, -1, 0, 8'hC3, 1));
        vecs.push_back(dv(1, 0, 3, 8'h11, -1, -1, 0, 8'h4B, 0));
        vecs.push_back(dv(1, 0, 2, 8'h21, 3, -1, 0, 8'h4B, 1));
        vecs.push_back(dv(1, 0, 1, 8'h31, 0, -1, 0, 8'hC3, 1));
        vecs.push_back(dv(0, 1, 0, 8'h00, -1, -1, 0, 8'hC3, 0));
        vecs.push_back(dv(0, 1, 0, 8'h00, 4, 0, 0, 8'h4B, 1));
        vecs.push_back(dv(2, 0, 5, 8'h40, int'(TIMEOUT) - 1, -1, 0, 8'hC3, 1));
        vecs.push_back(dv(3, 0, 4, 8'h50, 2, -1, 0, 8'hC3, 1));
        vecs.push_back(dv(3, 0, 2, 8'h60, 1, -1, 1, 8'h4B, 1));
        vecs.push_back(dv(3, 0, 1, 8'h70, 1, -1, 0, 8'h4B, 1));
        vecs.push_back(dv(2, 0, 2, 8'h80, 0, -1, 0, 8'h4B, 1));

        foreach (vecs[i]) begin
            wait_idle();
            if (vecs[i].hsk) run_hsk(vecs[i]);
            else             run_dat(vecs[i]);
        end

        // Handshake and data requested together: handshake first, data follows.
        wait_idle();
        h0 = hsk_ack_cnt;
        d0 = pkt_done_cnt;
        sbq.push_back(8'h5A);
        v = dv(2, 0, 2, 8'h90, 2, -1, 0, 8'hC3, 1);
        queue_packet(v);
        hsk_sel = 2'b10;
        dat_ep  = 2'd2;
        dat_zlp = 1'b0;
        hsk_req = 1'b1;
        dat_req = 1'b1;
        tick();
        check("both_hsk_first", 32'(enc.hsk_send), 32'd1);
        check("both_no_start", 32'(enc.trn_start), 32'd0);
        n = 0;
        while (!hsk_ack && n < 200) begin
            tick();
            n++;
        end
        check("both_hsk_ack", 32'(hsk_ack), 32'd1);
        hsk_req = 1'b0;
        finish_data(v, d0);
        tick();
        check("both_hsk_pulses", 32'(hsk_ack_cnt - h0), 32'd1);

        // Reset in the middle of an ep1 transfer (toggle is DATA1 beforehand).
        wait_idle();
        c0 = dat_ack_cnt;
        v = dv(1, 0, 6, 8'hB0, 0, -1, 0, 8'h4B, 1);
        queue_packet(v);
        dat_ep  = 2'd1;
        dat_zlp = 1'b0;
        dat_req = 1'b1;
        n = 0;
        while (epq[1].size() > 4 && n < 500) begin
            tick();
            n++;
        end
        check("rst_mid_progress", 32'(epq[1].size() <= 4), 32'd1);
        reset_n = 1'b0;
        dat_req = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tvalid", 32'(enc.trn_tvalid), 32'd0);
        check("midrst_tlast", 32'(enc.trn_tlast), 32'd0);
        check("midrst_ep_tready", 32'(ep_tready), 32'd0);
        check("midrst_hsk_send", 32'(enc.hsk_send), 32'd0);
        sbq.delete();
        tick();
        reset_n = 1'b1;
        tick();
        check("midrst_no_ack", 32'(dat_ack_cnt - c0), 32'd0);
        wait_idle();
        run_dat(dv(1, 0, 2, 8'hA0, 2, -1, 0, 8'hC3, 1));
        wait_idle();
        run_dat(dv(2, 0, 1, 8'hC0, 1, -1, 0, 8'hC3, 1));

        repeat (5) tick();
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
